// File: rtl/ram_pkg.sv
// Shared defaults and FSM encoding for the RAM block-copy engine.
package ram_pkg;

    localparam int AW_DEFAULT = 14;
    localparam int DW_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/copy_counter.sv
// Source/destination word pointers and remaining-word count for one copy.
// Pointers step together, up or down as chosen at load; count steps down.
module copy_counter
    import ram_pkg::*;
#(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic [AW-1:0] src_load,
    input  logic [AW-1:0] dst_load,
    input  logic [AW:0]   cnt_load,
    input  logic          down_load,
    input  logic          step_ptr,
    input  logic          dec_cnt,
    output logic [AW-1:0] src_ptr,
    output logic [AW-1:0] dst_ptr,
    output logic          zero
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [AW-1:0] src_reg;
    logic [AW-1:0] dst_reg;
    logic [AW:0]   cnt_reg;
    logic          down_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            src_reg  <= '0;
            dst_reg  <= '0;
            cnt_reg  <= '0;
            down_reg <= 1'b0;
        end else if (load) begin
            src_reg  <= src_load;
            dst_reg  <= dst_load;
            cnt_reg  <= cnt_load;
            down_reg <= down_load;
        end else begin
            // Pointer arithmetic is modulo 2^AW; wrapping is intentional.
            if (step_ptr) begin
                if (down_reg) begin
                    src_reg <= src_reg - PTR_ONE;
                    dst_reg <= dst_reg - PTR_ONE;
                end else begin
                    src_reg <= src_reg + PTR_ONE;
                    dst_reg <= dst_reg + PTR_ONE;
                end
            end
            if (dec_cnt) begin
                cnt_reg <= cnt_reg - CNT_ONE;
            end
        end
    end

    assign src_ptr = src_reg;
    assign dst_ptr = dst_reg;
    assign zero    = (cnt_reg == '0);

endmodule

// File: rtl/ram_block_copy.sv
// Word-by-word block copy within one single-port RAM (read cycle, write cycle).
// Define RAM_BLOCK_COPY_OVERLAP_EN to copy descending when a forward copy overlaps.
module ram_block_copy
    import ram_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src,
    input  logic [AW-1:0] dst,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_add,
    output logic [DW-1:0] ram_in,
    output logic          ram_load,
    input  logic [DW-1:0] ram_out
);

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

    state_t        state_reg;
    state_t        state_next;
    logic [DW-1:0] data_reg;

    logic [AW:0]   len_clamped;
    logic [AW-1:0] src_first;
    logic [AW-1:0] dst_first;
    logic          go_down;
    logic          load;
    logic          step_ptr;
    logic          dec_cnt;
    logic [AW-1:0] src_ptr;
    logic [AW-1:0] dst_ptr;
    logic          zero;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

`ifdef RAM_BLOCK_COPY_OVERLAP_EN
    logic [AW:0] src_ext;
    logic [AW:0] dst_ext;
    logic [AW:0] src_end;
    logic [AW:0] len_m1;

    // Unwrapped compare: only a true forward overlap triggers a descending copy.
    assign src_ext   = {1'b0, src};
    assign dst_ext   = {1'b0, dst};
    assign src_end   = src_ext + len_clamped;
    assign len_m1    = len_clamped - (AW + 1)'(1);
    assign go_down   = (dst_ext > src_ext) && (dst_ext < src_end);
    assign src_first = go_down ? (src + len_m1[AW-1:0]) : src;
    assign dst_first = go_down ? (dst + len_m1[AW-1:0]) : dst;
`else
    assign go_down   = 1'b0;
    assign src_first = src;
    assign dst_first = dst;
`endif

    copy_counter #(
        .AW(AW)
    ) u_counter (
        .clk      (clk),
        .srst     (rst),
        .load     (load),
        .src_load (src_first),
        .dst_load (dst_first),
        .cnt_load (len_clamped),
        .down_load(go_down),
        .step_ptr (step_ptr),
        .dec_cnt  (dec_cnt),
        .src_ptr  (src_ptr),
        .dst_ptr  (dst_ptr),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RD) begin
                data_reg <= ram_out;
            end
        end
    end

    // Count is decremented in RD so that WR sees whether this was the last word.
    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step_ptr   = 1'b0;
        dec_cnt    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        ram_add    = '0;
        ram_in     = '0;
        ram_load   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = (len_clamped == '0) ? FIN : RD;
                end
            end
            RD: begin
                busy       = 1'b1;
                ram_add    = src_ptr;
                dec_cnt    = 1'b1;
                state_next = WR;
            end
            WR: begin
                busy       = 1'b1;
                ram_add    = dst_ptr;
                ram_in     = data_reg;
                ram_load   = 1'b1;
                step_ptr   = 1'b1;
                state_next = zero ? FIN : RD;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_block_copy.sv
// Directed bench for ram_block_copy: a behavioural RAM, a queue of expected
// writes checked as the DUT issues them, and timing/memory checks per copy.
module tb_ram_block_copy;

    localparam int AW = 14;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src = '0;
    logic [AW-1:0] dst = '0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_add;
    logic [DW-1:0] ram_in;
    logic          ram_load;
    logic [DW-1:0] ram_out;

    logic [DW-1:0] mem [0:DEPTH-1];

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    bit  mon_en = 1'b0;

    always #5 clk = ~clk;

    ram_block_copy #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .src     (src),
        .dst     (dst),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .ram_add (ram_add),
        .ram_in  (ram_in),
        .ram_load(ram_load),
        .ram_out (ram_out)
    );

    assign ram_out = mem[ram_add];

    always @(posedge clk) begin
        if (ram_load) mem[ram_add] <= ram_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Every write the DUT issues must match the head of the expected queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_load === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(ram_load), 32'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(ram_add), 32'(e.a));
                    chk("wr_data", 32'(ram_in), 32'(e.d));
                end
            end else if (ram_in !== '0) begin
                chk("ram_in_not_wr", 32'(ram_in), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input int a, input int d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic start_copy(input int s, input int d, input int l);
        src   = AW'(s);
        dst   = AW'(d);
        len   = (AW + 1)'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // i0 numbers the current sample; the cycle right after the accepting edge is 1.
    task automatic wait_done(input int i0, output int busy_cnt, output int done_at);
        busy_cnt = 0;
        done_at  = -1;
        for (int i = i0; i < i0 + 40000; i++) begin
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
            tick();
        end
    endtask

    task automatic run_check(input string tag, input int l, input int i0, input int busy_pre);
        int b;
        int d;
        wait_done(i0, b, d);
        chk({tag, "_done_at"}, 32'(d), 32'(1 + 2 * l));
        chk({tag, "_busy_cycles"}, 32'(b + busy_pre), 32'(2 * l));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i ^ 16'h5A5A);

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_load", 32'(ram_load), 32'd0);
        chk("rst_ram_add", 32'(ram_add), 32'd0);
        chk("rst_ram_in", 32'(ram_in), 32'd0);
        mon_en = 1'b1;

        // rst wins over start in the same cycle
        src = 14'd5; dst = 14'd50; len = 15'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_prio_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_prio_busy2", 32'(busy), 32'd0);
        chk("rst_prio_done", 32'(done), 32'd0);

        // Basic copy
        mem[100] = 16'd11; mem[101] = 16'd22; mem[102] = 16'd33; mem[103] = 16'd44;
        push_wr(200, 11); push_wr(201, 22); push_wr(202, 33); push_wr(203, 44);
        start_copy(100, 200, 4);
        run_check("basic", 4, 1, 0);
        chk("basic_m200", 32'(mem[200]), 32'd11);
        chk("basic_m203", 32'(mem[203]), 32'd44);
        $display("txn basic src=100 dst=200 len=4 checks=%0d failures=%0d", checks, failures);

        // Zero length: no write, done right after acceptance, busy never high
        start_copy(300, 900, 0);
        run_check("len0", 0, 1, 0);
        $display("txn len0 src=300 dst=900 len=0 checks=%0d failures=%0d", checks, failures);

        // Source wraps 16383 -> 0
        mem[16382] = 16'd5; mem[16383] = 16'd6; mem[0] = 16'd7; mem[1] = 16'd8;
        push_wr(10, 5); push_wr(11, 6); push_wr(12, 7); push_wr(13, 8);
        start_copy(16382, 10, 4);
        run_check("wrap", 4, 1, 0);
        chk("wrap_m13", 32'(mem[13]), 32'd8);
        $display("txn wrap src=16382 dst=10 len=4 checks=%0d failures=%0d", checks, failures);

        // Overlapping forward copy
        for (int i = 0; i < 5; i++) mem[i] = 16'(i + 1);
`ifdef RAM_BLOCK_COPY_OVERLAP_EN
        push_wr(4, 3); push_wr(3, 2); push_wr(2, 1);
`else
        push_wr(2, 1); push_wr(3, 2); push_wr(4, 1);
`endif
        start_copy(0, 2, 3);
        run_check("overlap", 3, 1, 0);
        chk("overlap_m2", 32'(mem[2]), 32'd1);
        chk("overlap_m3", 32'(mem[3]), 32'd2);
`ifdef RAM_BLOCK_COPY_OVERLAP_EN
        chk("overlap_m4", 32'(mem[4]), 32'd3);
`else
        chk("overlap_m4", 32'(mem[4]), 32'd1);
`endif
        $display("txn overlap src=0 dst=2 len=3 checks=%0d failures=%0d", checks, failures);

        // start while busy is ignored
        push_wr(600, 11); push_wr(601, 22); push_wr(602, 33); push_wr(603, 44);
        start_copy(100, 600, 4);
        tick();
        tick();
        src = 14'd700; dst = 14'd800; len = 15'd2; start = 1'b1;
        tick();
        start = 1'b0;
        run_check("busy_start", 4, 4, 3);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) cnt++;
            tick();
        end
        chk("busy_start_extra_done", 32'(cnt), 32'd0);
        $display("txn busy_start src=100 dst=600 len=4 checks=%0d failures=%0d", checks, failures);

        // Reset after the third of eight words
        for (int i = 0; i < 8; i++) begin
            mem[300 + i] = 16'(1000 + i);
            mem[400 + i] = 16'hAAAA;
        end
        push_wr(400, 1000); push_wr(401, 1001); push_wr(402, 1002);
        start_copy(300, 400, 8);
        for (int i = 0; i < 5; i++) tick();
        chk("midrst_wr2_active", 32'(ram_load), 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_load_off", 32'(ram_load), 32'd0);
        chk("midrst_busy_off", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("midrst_m402", 32'(mem[402]), 32'd1002);
        chk("midrst_m403", 32'(mem[403]), 32'hAAAA);
        chk("midrst_m407", 32'(mem[407]), 32'hAAAA);
        chk("midrst_queue", 32'(exp_q.size()), 32'd0);
        push_wr(500, 1000);
        start_copy(300, 500, 1);
        run_check("after_rst", 1, 1, 0);
        $display("txn midrst src=300 dst=400 len=8 checks=%0d failures=%0d", checks, failures);

        // Oversized length clamps to 2^AW; src == dst leaves data unchanged
        for (int i = 0; i < DEPTH; i++) push_wr(i, int'(mem[i]));
        start_copy(0, 0, DEPTH + 5);
        run_check("clamp", DEPTH, 1, 0);
        chk("clamp_m100", 32'(mem[100]), 32'd11);
        $display("txn clamp src=0 dst=0 len=%0d checks=%0d failures=%0d", DEPTH + 5, checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_block_copy.md
RAM_BLOCK_COPY -- requirements
Module: ram_block_copy

Interface
REQ-001 Parameter AW, default 14, address width of the attached ram16k.
REQ-002 Parameter DW, default 16, data word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-006 src  input  AW  first source word address, latched on accepted start.
REQ-007 dst  input  AW  first destination word address, latched on accepted start.
REQ-008 len  input  AW+1  word count, 0..2^AW, latched on accepted start.
REQ-009 busy  output  1  high while a copy is in progress (RD/WR states).
REQ-010 done  output  1  one-cycle pulse on copy completion.
REQ-011 ram_add  output  AW  address to ram16k.
REQ-012 ram_in  output  DW  write data to ram16k.
REQ-013 ram_load  output  1  write enable to ram16k.
REQ-014 ram_out  input  DW  read data from ram16k, combinational on ram_add.

Function
REQ-015 The FSM SHALL have states IDLE, RD, WR, FIN.
- IDLE, start=1, latched len>0 -> RD.
- IDLE, start=1, len=0 -> FIN.
- RD -> WR unconditionally.
- WR -> RD if words remain, else FIN.
- FIN -> IDLE.
REQ-016 In RD, ram_add SHALL equal the current source pointer, ram_load=0, and ram_out SHALL be captured into a DW-bit data register at the cycle's end.
REQ-017 In WR, ram_add SHALL equal the current destination pointer, ram_in the captured word, and ram_load=1.
REQ-018 Pointers SHALL step by one per word, modulo 2^AW; address wrap 16383->0 is legal and silent.
REQ-019 len > 2^AW SHALL be clamped to 2^AW.
REQ-020 Copy latency: start accepted at edge k -> done high in the cycle after 1+2*len cycles; busy high for exactly 2*len cycles.
REQ-021 start while busy or in FIN SHALL be ignored; no queuing.
REQ-022 ram_load SHALL be 0 in every state except WR; ram_in SHALL be 0 outside WR.
REQ-023 src=dst SHALL perform the copy normally (data unchanged, 2*len cycles).

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, ram_load=0, ram_add=0, ram_in=0, pointers/count/data register 0.
REQ-025 Reset mid-copy SHALL abort without issuing any further write; already written words stay written.
REQ-026 rst has priority over start in the same cycle.

Configuration
REQ-027 Macro RAM_BLOCK_COPY_OVERLAP_EN defined: when dst>src and dst<src+len (unwrapped AW+1-bit compare), the copy SHALL run descending from src+len-1/dst+len-1, so overlapping data is preserved.
REQ-028 Macro undefined: copies SHALL always run ascending; overlapping forward copies yield replicated data, by design.

Structure
REQ-029 Shared package ram_pkg SHALL hold AW/DW defaults and the FSM state encoding.
REQ-030 One sub-module copy_counter SHALL hold the source/destination pointers and remaining count (load, step up/down, zero flag).

Verification
REQ-031 Preload mem[100..103]=11,22,33,44; start src=100 dst=200 len=4 -> mem[200..203]=11,22,33,44; busy 8 cycles; done 1 cycle.
REQ-032 start len=0 -> no ram_load pulse; done 2 cycles after start edge; busy never high.
REQ-033 src=16382 dst=10 len=4, mem[16382,16383,0,1]=5,6,7,8 -> mem[10..13]=5,6,7,8.
REQ-034 mem[0..4]=1..5, src=0 dst=2 len=3: macro defined -> mem[2..4]=1,2,3; undefined -> mem[2..4]=1,2,1.
REQ-035 rst asserted after 3 words of len=8 -> ram_load=0 next cycle, only 3 destination words changed, IDLE; new start accepted.
REQ-036 start pulsed again during busy -> ignored; exactly one done pulse.
